// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
//  Module      : ram_arbiter_pkg
//  Description : Shared state encodings, master IDs and default widths for
//                the two-master RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_RSP0 = 2'd1;
    localparam arb_state_t ARB_RSP1 = 2'd2;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 32;
    localparam int ARB_MW = 4;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
//  Module      : ram_arbiter_if
//  Description : One master's request/response channel pair into the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW,
    parameter int MW = ARB_MW
);

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [MW-1:0] req_wem;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wem, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wem, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

`default_nettype wire

// File: rtl/ram_arbiter_rr2.sv
// ============================================================================
//  Module      : arb_rr2
//  Description : Two-way one-hot grant picker. Ties go round robin, or always
//                to master 1 when RAM_ARB_FIXED_PRIO_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr2
    import ram_arbiter_pkg::*;
(
    input  wire logic [1:0] req,
    input  wire logic       last_grant,
    input  wire logic       enable,
    output logic      [1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
`ifdef RAM_ARB_FIXED_PRIO_EN
                2'b11:   gnt = 2'b10;
`else
                2'b11:   gnt = (last_grant == ARB_M1) ? 2'b01 : 2'b10;
`endif
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one single-port RAM between fetch (m0) and load/store
//                (m1) masters with a one-deep registered response per grant.
//                Optional macro: RAM_ARB_FIXED_PRIO_EN (m1 wins ties).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW,
    parameter int MW = ARB_MW
)(
    input  wire logic          clk,
    input  wire logic          rst,
    ram_arbiter_if.slave       m0,
    ram_arbiter_if.slave       m1,
    output logic               ram_cs,
    output logic               ram_we,
    output logic      [MW-1:0] ram_wem,
    output logic      [AW-1:0] ram_addr,
    output logic      [DW-1:0] ram_din,
    input  wire logic [DW-1:0] ram_dout
);

    arb_state_t    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic          free;
    logic [1:0]    gnt;

    // The response buffer frees up in the same cycle its content is consumed,
    // which is what allows one transaction per cycle.
    always_comb begin
        case (state_q)
            ARB_IDLE: free = 1'b1;
            ARB_RSP0: free = m0.rsp_ready;
            ARB_RSP1: free = m1.rsp_ready;
            default:  free = 1'b1;
        endcase
    end

    arb_rr2 u_pick (
        .req        ({m1.req_valid, m0.req_valid}),
        .last_grant (last_grant_q),
        .enable     (free),
        .gnt        (gnt)
    );

    assign m0.req_ready = gnt[0];
    assign m1.req_ready = gnt[1];

    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt[1]) begin
            ram_cs   = 1'b1;
            ram_we   = m1.req_we;
            ram_wem  = m1.req_wem;
            ram_addr = m1.req_addr;
            ram_din  = m1.req_wdata;
        end else if (gnt[0]) begin
            ram_cs   = 1'b1;
            ram_we   = m0.req_we;
            ram_wem  = m0.req_wem;
            ram_addr = m0.req_addr;
            ram_din  = m0.req_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_M1;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    // Next-state and datapath capture
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        if (gnt[0]) begin
            state_d      = ARB_RSP0;
            last_grant_d = ARB_M0;
            rsp0_rdata_d = m0.req_we ? '0 : ram_dout;
        end else if (gnt[1]) begin
            state_d      = ARB_RSP1;
            last_grant_d = ARB_M1;
            rsp1_rdata_d = m1.req_we ? '0 : ram_dout;
        end else if (free) begin
            state_d      = ARB_IDLE;
        end
    end

    // Outputs
    always_comb begin
        m0.rsp_valid = (state_q == ARB_RSP0);
        m1.rsp_valid = (state_q == ARB_RSP1);
        m0.rsp_rdata = rsp0_rdata_q;
        m1.rsp_rdata = rsp1_rdata_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed self-checking bench for ram_arbiter with a small
//                behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic        ram_cs, ram_we;
    logic [3:0]  ram_wem;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic [31:0] mem [0:63];
    logic [1:0]  exp_gnt, prev_gnt;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter_if m0_if ();
    ram_arbiter_if m1_if ();

    ram_arbiter u_dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_wem  (ram_wem),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    assign ram_dout = mem[6'(ram_addr >> 2)];

    always @(posedge clk) begin
        if (preload) begin
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'hFFFFFFFF;
        end else if (ram_cs && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_wem[b]) mem[6'(ram_addr >> 2)][8*b +: 8] <= ram_din[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic req0(input logic v, input logic we, input logic [31:0] a,
                        input logic [3:0] wem, input logic [31:0] wd);
        m0_if.req_valid = v; m0_if.req_we = we; m0_if.req_addr = a;
        m0_if.req_wem = wem; m0_if.req_wdata = wd;
    endtask

    task automatic req1(input logic v, input logic we, input logic [31:0] a,
                        input logic [3:0] wem, input logic [31:0] wd);
        m1_if.req_valid = v; m1_if.req_we = we; m1_if.req_addr = a;
        m1_if.req_wem = wem; m1_if.req_wdata = wd;
    endtask

    function automatic logic [31:0] gnt_now();
        return {30'd0, m1_if.req_ready, m0_if.req_ready};
    endfunction

    initial begin
        rst = 1'b1; preload = 1'b1;
        req0(0, 0, 0, 0, 0); req1(0, 0, 0, 0, 0);
        m0_if.rsp_ready = 1'b1; m1_if.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        preload = 1'b0; rst = 1'b0;

        // Reset state and first idle edge
        #1;
        chk("rst_cs", ram_cs, 0);
        chk("rst_v0", m0_if.rsp_valid, 0);
        chk("rst_v1", m1_if.rsp_valid, 0);
        chk("rst_d0", m0_if.rsp_rdata, 0);
        @(negedge clk); #1;
        chk("idle_cs", ram_cs, 0);
        chk("idle_v0", m0_if.rsp_valid, 0);

        // m0 read 0x10
        @(negedge clk); req0(1, 0, 32'h10, 0, 0); #1;
        chk("rd0_gnt", gnt_now(), 32'd1);
        chk("rd0_cs", ram_cs, 1);
        chk("rd0_addr", ram_addr, 32'h10);
        chk("rd0_we", ram_we, 0);
        @(negedge clk); req0(0, 0, 0, 0, 0); #1;
        chk("rd0_v", m0_if.rsp_valid, 1);
        chk("rd0_data", m0_if.rsp_rdata, 32'hDEADBEEF);
        chk("rd0_v1", m1_if.rsp_valid, 0);
        @(negedge clk); #1;
        chk("rd0_done", m0_if.rsp_valid, 0);

        // m1 masked write then read-back
        @(negedge clk); req1(1, 1, 32'h20, 4'b0011, 32'h12345678); #1;
        chk("wr1_gnt", gnt_now(), 32'd2);
        chk("wr1_we", ram_we, 1);
        chk("wr1_wem", ram_wem, 4'b0011);
        chk("wr1_din", ram_din, 32'h12345678);
        @(negedge clk); req1(1, 0, 32'h20, 0, 0); #1;
        chk("wr1_v", m1_if.rsp_valid, 1);
        chk("wr1_data", m1_if.rsp_rdata, 0);
        chk("rd1_gnt", gnt_now(), 32'd2);
        @(negedge clk); req1(0, 0, 0, 0, 0); #1;
        chk("rd1_data", m1_if.rsp_rdata, 32'hFFFF5678);
        @(negedge clk);

        // Both masters requesting every cycle
        req0(1, 0, 32'h10, 0, 0); req1(1, 0, 32'h20, 0, 0);
        prev_gnt = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_gnt = 2'b10;
`else
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk($sformatf("tie_gnt%0d", i), gnt_now(), {30'd0, exp_gnt});
            if (prev_gnt == 2'b01) begin
                chk($sformatf("tie_v0_%0d", i), m0_if.rsp_valid, 1);
                chk($sformatf("tie_d0_%0d", i), m0_if.rsp_rdata, 32'hDEADBEEF);
            end else if (prev_gnt == 2'b10) begin
                chk($sformatf("tie_v1_%0d", i), m1_if.rsp_valid, 1);
                chk($sformatf("tie_d1_%0d", i), m1_if.rsp_rdata, 32'hFFFF5678);
            end
            prev_gnt = exp_gnt;
            @(negedge clk);
        end
        req0(0, 0, 0, 0, 0); req1(0, 0, 0, 0, 0);
        @(negedge clk);

        // Response stall on m0 while m1 waits
        m0_if.rsp_ready = 1'b0; req0(1, 0, 32'h10, 0, 0); #1;
        chk("stl_gnt", gnt_now(), 32'd1);
        @(negedge clk); req0(0, 0, 0, 0, 0); req1(1, 0, 32'h20, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stl_rdy1_%0d", i), m1_if.req_ready, 0);
            chk($sformatf("stl_cs_%0d", i), ram_cs, 0);
            chk($sformatf("stl_v0_%0d", i), m0_if.rsp_valid, 1);
            chk($sformatf("stl_d0_%0d", i), m0_if.rsp_rdata, 32'hDEADBEEF);
            @(negedge clk);
        end
        m0_if.rsp_ready = 1'b1; #1;
        chk("stl_rel_rdy1", m1_if.req_ready, 1);
        chk("stl_rel_cs", ram_cs, 1);
        @(negedge clk); req1(0, 0, 0, 0, 0); #1;
        chk("stl_v1", m1_if.rsp_valid, 1);
        chk("stl_d1", m1_if.rsp_rdata, 32'hFFFF5678);
        chk("stl_v0_off", m0_if.rsp_valid, 0);
        @(negedge clk);

        // Write with an empty byte mask
        req0(1, 1, 32'h10, 4'b0000, 32'h0); #1;
        chk("wm0_gnt", gnt_now(), 32'd1);
        @(negedge clk); req0(1, 0, 32'h10, 0, 0); #1;
        chk("wm0_v", m0_if.rsp_valid, 1);
        chk("wm0_data", m0_if.rsp_rdata, 0);
        @(negedge clk); req0(0, 0, 0, 0, 0); #1;
        chk("wm0_keep", m0_if.rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);

        // Reset with a response pending
        m0_if.rsp_ready = 1'b0; req0(1, 0, 32'h10, 0, 0);
        @(negedge clk); req0(0, 0, 0, 0, 0); #1;
        chk("mrst_pre_v0", m0_if.rsp_valid, 1);
        rst = 1'b1; #1;
        chk("mrst_v0", m0_if.rsp_valid, 0);
        chk("mrst_d0", m0_if.rsp_rdata, 0);
        @(negedge clk); rst = 1'b0; m0_if.rsp_ready = 1'b1;
        req0(1, 0, 32'h10, 0, 0); req1(1, 0, 32'h20, 0, 0); #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("mrst_tie", gnt_now(), 32'd2);
`else
        chk("mrst_tie", gnt_now(), 32'd1);
`endif
        @(negedge clk); req0(0, 0, 0, 0, 0); req1(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
